// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: FSM state encoding and width helper for the round-robin FIFO drain scheduler
package fifo_sched_pkg;
    typedef enum logic {ST_ARB = 1'b0, ST_BURST = 1'b1} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_sched_obuf.sv
// fifo_sched_obuf: 2-entry in-order {src,data} output buffer with valid/ready drain
module fifo_sched_obuf #(
    parameter int DW = 8,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [SW-1:0] push_src,
    input  logic [DW-1:0] push_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [SW-1:0] out_src,
    output logic [1:0]    occ
);
    logic [SW+DW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0] occ_q, occ_d, slot;
    logic pop;
    always_comb begin
        pop = (occ_q != 2'd0) && out_ready;
        slot = occ_q - {1'b0, pop};
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        e0_d = (pop && occ_q == 2'd2) ? e1_q : e0_q;
        e1_d = e1_q;
        if (push && slot == 2'd0) e0_d = {push_src, push_data};
        if (push && slot == 2'd1) e1_d = {push_src, push_data};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q <= '0;
            e1_q <= '0;
            occ_q <= '0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            occ_q <= occ_d;
        end
    end
    assign out_valid = occ_q != 2'd0;
    assign {out_src, out_data} = e0_q;
    assign occ = occ_q;
endmodule

// File: rtl/fifo_rr_drain_sched.sv
// fifo_rr_drain_sched: round-robin burst drain of N FIFOs into one stream; FIFO_SCHED_PRIO0_EN gives FIFO 0 strict priority
module fifo_rr_drain_sched
    import fifo_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                fifo_empty,
    output logic [N-1:0]                fifo_rd_en,
    input  logic [N*DW-1:0]             fifo_dout,
    output logic                        out_valid,
    output logic [DW-1:0]               out_data,
    output logic [clog2(N)-1:0]         out_src,
    input  logic                        out_ready
);
    localparam int SW = clog2(N);
    localparam int CW = clog2(BURST + 1);
    state_t state_q, state_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, infl_src_q, infl_src_d, pick, cand;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic infl_q, infl_d, found, skip0, credit, lim_ok, rd;
    logic [1:0] occ;
    always_comb begin
        int idx;
        found = 1'b0;
        pick = '0;
        cand = '0;
        skip0 = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            cand = SW'(idx);
`ifdef FIFO_SCHED_PRIO0_EN
            skip0 = cand == '0;
`endif
            if (!found && !skip0 && !fifo_empty[cand]) begin
                found = 1'b1;
                pick = cand;
            end
        end
`ifdef FIFO_SCHED_PRIO0_EN
        if (!fifo_empty[0]) begin
            found = 1'b1;
            pick = '0;
        end
`endif
    end
    always_comb begin
        credit = (occ + {1'b0, infl_q}) < 2'd2;
`ifdef FIFO_SCHED_PRIO0_EN
        lim_ok = (gnt_q == '0) || (burst_cnt_q < CW'(BURST));
`else
        lim_ok = burst_cnt_q < CW'(BURST);
`endif
        rd = (state_q == ST_BURST) && !fifo_empty[gnt_q] && credit && lim_ok;
        fifo_rd_en = rd ? (N'(1) << gnt_q) : '0;
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d = gnt_q;
        burst_cnt_d = burst_cnt_q;
        infl_d = rd;
        infl_src_d = gnt_q;
        if (state_q == ST_ARB && found) begin
            state_d = ST_BURST;
            gnt_d = pick;
            burst_cnt_d = '0;
`ifdef FIFO_SCHED_PRIO0_EN
            rr_ptr_d = (pick == '0) ? rr_ptr_q : pick;
`else
            rr_ptr_d = pick;
`endif
        end
        if (state_q == ST_BURST) begin
            burst_cnt_d = (rd && burst_cnt_q < CW'(BURST)) ? burst_cnt_q + 1'b1 : burst_cnt_q;
            // a credit stall alone keeps the grant; only empty or an exhausted burst releases it
            if (!rd && (fifo_empty[gnt_q] || !lim_ok)) state_d = ST_ARB;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            rr_ptr_q <= SW'(N - 1);
            gnt_q <= '0;
            burst_cnt_q <= '0;
            infl_q <= 1'b0;
            infl_src_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q <= gnt_d;
            burst_cnt_q <= burst_cnt_d;
            infl_q <= infl_d;
            infl_src_q <= infl_src_d;
        end
    end
    fifo_sched_obuf #(.DW(DW), .SW(SW)) u_obuf (
        .clk(clk),
        .rst(rst),
        .push(infl_q),
        .push_src(infl_src_q),
        .push_data(fifo_dout[int'(infl_src_q)*DW +: DW]),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .occ(occ)
    );
endmodule
